fm_mod_top: RTL and testbench
=============================

// Module: fm_mod_top
// PURPOSE
//  - FM modulator: inverse of the demodulation stage. Takes 32-bit signed quantized audio samples and emits complex baseband I/Q samples.
//  - Each sample advances a phase accumulator by din*GAIN; cos/sin of the accumulated phase give real/imag.
//  - FIFO-wrapped on both sides, same handshake style as demod_top. Feeds the complex FIR/demod chain in loopback benches.
// PARAMETERS
//  QUANT_BITS   10     fixed-point fraction bits; full-scale output magnitude = 1<<QUANT_BITS
//  GAIN         1      integer phase-increment gain (signed 32-bit)
//  LUT_ADDR_W   10     quarter-wave index bits; table holds 2**LUT_ADDR_W+1 entries
//  FIFO_DEPTH   16     depth of the input and output FIFOs (power of 2)
//  MAX_INC      32'h2000_0000  |increment| clamp, used only with FM_MOD_SAT_EN
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  reset           in   1   asynchronous, active-low reset
//  din             in   32  signed audio sample
//  in_fifo_wr_en   in   1   push din into input FIFO
//  in_fifo_full    out  1   input FIFO full
//  out_fifo_rd_en  in   1   pop current real_out/imag_out
//  real_out        out  32  I sample, sign-extended Q(QUANT_BITS)
//  imag_out        out  32  Q sample, sign-extended Q(QUANT_BITS)
//  out_fifo_empty  out  1   output FIFO empty
// BEHAVIOUR
//  - Reset (reset=0, async): FIFOs empty, phase=0, FSM=S_IDLE; in_fifo_full=0, out_fifo_empty=1, real_out=imag_out=0. Mid-operation reset drops in-flight samples.
//  - Output FIFO is show-ahead: real_out/imag_out are valid whenever out_fifo_empty=0; out_fifo_rd_en pops on the edge.
//  - wr_en while full and rd_en while empty are ignored: no state change, no corruption. Simultaneous push and pop are legal on the same FIFO.
//  - FSM:
//    - S_IDLE: if input FIFO not empty AND output FIFO not full -> pop, latch din -> S_CALC; otherwise stay.
//    - S_CALC: inc = low 32 bits of din*GAIN (two's complement wrap); phase <= phase + inc mod 2**32 -> S_LUT.
//    - S_LUT: quadrant = phase[31:30]; idx = phase[29:30-LUT_ADDR_W]; register cos/sin via mirroring -> S_WRITE.
//    - S_WRITE: push {real,imag} -> S_IDLE.
//  - Quadrant mapping, with s(k) = table[k]:
//    - q0: sin=s(i), cos=s(N-i)
//    - q1: sin=s(N-i), cos=-s(i)
//    - q2: sin=-s(i), cos=-s(N-i)
//    - q3: sin=-s(N-i), cos=s(i)
//    - N = 2**LUT_ADDR_W.
//  - table[k] = round(sin(k*pi/2/N) * 2**QUANT_BITS).
//  - Phase is truncated, not interpolated.
//  - Output uses the phase AFTER adding the current sample's increment.
//  - Latency: din written at edge 0 -> out_fifo_empty falls after edge 5. Throughput: 1 sample per 4 clocks.
//  - Phase wraps silently at 2**32 (= 2*pi).
//  - Output-full backpressure holds the FSM in S_IDLE; no sample is lost.
// CONFIGURATION
//  - FM_MOD_SAT_EN defined: inc is clamped to [-MAX_INC, +MAX_INC] before accumulation.
//  - FM_MOD_SAT_EN undefined: inc wraps as computed and MAX_INC is unused.
// STRUCTURE
//  - fm_mod_pkg holds:
//    - QUANT_BITS default and LUT_ADDR_W default
//    - state_t enum {S_IDLE, S_CALC, S_LUT, S_WRITE}
//    - PHASE_W=32
//    - function quantize(real) used to build the table
//  - Sub-module fm_sincos_lut: quarter-wave ROM plus quadrant mirroring, registered cos/sin out.
//  - Input and output FIFOs reuse the team's existing fifo module (64-bit wide on the output side).
// TESTING
//  - Reset then din=0 -> real_out=0x00000400, imag_out=0x00000000; phase stays 0.
//  - din=0x40000000 three times -> (0,0x400), (0xFFFFFC00,0), (0,0xFFFFFC00).
//  - din=0xC0000000 (-pi/2) after reset -> (0,0xFFFFFC00); a following din=0x40000000 -> (0x400,0).
//  - Backpressure: write 40 samples with out_fifo_rd_en=0 -> exactly 16 outputs queued. in_fifo_full asserts. Draining yields all 40 in order versus the golden model.
//  - Reset asserted while FSM is in S_LUT -> outputs 0, out_fifo_empty=1 immediately. Next din=0 gives (0x400,0).
//  - FM_MOD_SAT_EN, din=0x7FFFFFFF -> inc clamped to 0x20000000; output (0x2D4,0x2D4) within ±1 LSB.

Source files
------------

// File: rtl/fm_mod_pkg.sv
// Shared types and constants for the FM modulator: FSM states, phase width,
// and the quantizer used to build the quarter-wave sine table.
package fm_mod_pkg;

  localparam int  QUANT_BITS_DEF = 10;
  localparam int  LUT_ADDR_W_DEF = 10;
  localparam int  PHASE_W        = 32;
  localparam real PI             = 3.14159265358979323846;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_LUT   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Real-to-int conversion rounds to nearest, half away from zero.
  function automatic int quantize(input real x, input int frac_bits = QUANT_BITS_DEF);
    return int'(x * real'(1 << frac_bits));
  endfunction

endpackage

// File: rtl/fifo.sv
// Shared synchronous FIFO with count-based flags. OUT_REG=0 reads straight from
// memory (show-ahead); OUT_REG=1 adds a registered show-ahead output stage.
module fifo #(
  parameter int W       = 32,
  parameter int DEPTH   = 16,
  parameter bit OUT_REG = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push;
  logic          mem_pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(mem_pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(mem_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [W-1:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic         user_pop;

    // Output register counts toward capacity so the FIFO never holds more than DEPTH.
    always_comb begin
      user_pop = rd_en && valid_q;
      mem_pop  = (cnt_q != '0) && (!valid_q || user_pop);
      valid_d  = mem_pop || (valid_q && !user_pop);
      dout_d   = mem_pop ? mem_q[rd_ptr_q] : dout_q;
      full     = (cnt_q + (AW+1)'(valid_q)) == (AW+1)'(DEPTH);
      push     = wr_en && !full;
      empty    = !valid_q;
      rd_data  = dout_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        valid_q <= valid_d;
        dout_q  <= dout_d;
      end
    end
  end else begin : g_direct
    always_comb begin
      empty   = (cnt_q == '0);
      full    = (cnt_q == (AW+1)'(DEPTH));
      push    = wr_en && !full;
      mem_pop = rd_en && !empty;
      rd_data = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/fm_sincos_lut.sv
// Quarter-wave sine ROM with quadrant mirroring; cos/sin registered when en is high,
// sign-extended to 32 bits.
module fm_sincos_lut
  import fm_mod_pkg::*;
#(
  parameter int QUANT_BITS = QUANT_BITS_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [LUT_ADDR_W+1:0] phase_msb,
  output logic [31:0]           cos_out,
  output logic [31:0]           sin_out
);

  localparam int                  N     = 1 << LUT_ADDR_W;
  localparam int                  ROM_W = QUANT_BITS + 1;
  localparam logic [LUT_ADDR_W:0] N_V   = (LUT_ADDR_W+1)'(N);

  logic [ROM_W-1:0] rom [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam real ANG = real'(k) * PI / (2.0 * real'(N));
    assign rom[k] = ROM_W'(quantize($sin(ANG), QUANT_BITS));
  end

  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [31:0]           s_i, s_ni;
  logic [31:0]           cos_q, cos_d, sin_q, sin_d;

  always_comb begin
    quad  = phase_msb[LUT_ADDR_W+1 -: 2];
    idx   = phase_msb[LUT_ADDR_W-1:0];
    s_i   = 32'(rom[{1'b0, idx}]);
    s_ni  = 32'(rom[N_V - {1'b0, idx}]);
    cos_d = cos_q;
    sin_d = sin_q;
    if (en) begin
      case (quad)
        2'd0:    begin sin_d = s_i;   cos_d = s_ni;  end
        2'd1:    begin sin_d = s_ni;  cos_d = -s_i;  end
        2'd2:    begin sin_d = -s_i;  cos_d = -s_ni; end
        default: begin sin_d = -s_ni; cos_d = s_i;   end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: rtl/fm_mod_top.sv
// FM modulator: per-sample phase accumulation, cos/sin lookup, FIFO-wrapped I/Q out.
// FM_MOD_SAT_EN: when defined, clamps each phase increment to +/-MAX_INC.
//
// state   | meaning
// S_IDLE  | wait for input sample and output space, pop and latch sample
// S_CALC  | phase += sample*GAIN (wrapping)
// S_LUT   | register cos/sin of new phase
// S_WRITE | push {cos, sin} into output FIFO
module fm_mod_top
  import fm_mod_pkg::*;
#(
  parameter int                 QUANT_BITS = QUANT_BITS_DEF,
  parameter int                 LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter logic signed [31:0] GAIN       = 32'sd1,
  parameter int                 FIFO_DEPTH = 16
`ifdef FM_MOD_SAT_EN
  ,
  parameter logic [31:0]        MAX_INC    = 32'h2000_0000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        in_fifo_wr_en,
  output logic        in_fifo_full,
  input  logic        out_fifo_rd_en,
  output logic [31:0] real_out,
  output logic [31:0] imag_out,
  output logic        out_fifo_empty
);

  logic [31:0]        in_data;
  logic               in_empty, out_full;
  logic               in_pop, out_push, lut_en;
  logic [31:0]        lut_cos, lut_sin;
  logic [63:0]        out_data;
  logic signed [31:0] inc;

  state_t             state_q, state_d;
  logic [31:0]        sample_q, sample_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  fifo #(.W(32), .DEPTH(FIFO_DEPTH), .OUT_REG(1'b0)) u_in_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_fifo_wr_en),
    .wr_data (din),
    .full    (in_fifo_full),
    .rd_en   (in_pop),
    .rd_data (in_data),
    .empty   (in_empty)
  );

  always_comb begin
    inc = $signed(sample_q) * GAIN;
`ifdef FM_MOD_SAT_EN
    if (inc > $signed(MAX_INC))       inc = $signed(MAX_INC);
    else if (inc < -$signed(MAX_INC)) inc = -$signed(MAX_INC);
`endif
  end

  // Only one sample is ever in flight, so space seen in S_IDLE is still there in S_WRITE.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    phase_d  = phase_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    lut_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_empty && !out_full) begin
          in_pop   = 1'b1;
          sample_d = in_data;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        phase_d = phase_q + $unsigned(inc);
        state_d = S_LUT;
      end
      S_LUT: begin
        lut_en  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        out_push = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      phase_q  <= phase_d;
    end
  end

  fm_sincos_lut #(.QUANT_BITS(QUANT_BITS), .LUT_ADDR_W(LUT_ADDR_W)) u_lut (
    .clk       (clk),
    .reset     (reset),
    .en        (lut_en),
    .phase_msb (phase_q[PHASE_W-1 -: LUT_ADDR_W+2]),
    .cos_out   (lut_cos),
    .sin_out   (lut_sin)
  );

  fifo #(.W(64), .DEPTH(FIFO_DEPTH), .OUT_REG(1'b1)) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (out_push),
    .wr_data ({lut_cos, lut_sin}),
    .full    (out_full),
    .rd_en   (out_fifo_rd_en),
    .rd_data (out_data),
    .empty   (out_fifo_empty)
  );

  assign real_out = out_data[63:32];
  assign imag_out = out_data[31:0];

endmodule

// File: tb/tb_fm_mod_top.sv
// Self-checking bench for fm_mod_top: directed vector table plus latency,
// backpressure and mid-operation reset sequences.
module tb_fm_mod_top;

  localparam real PI_TB = 3.14159265358979323846;
  localparam int  NBP   = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        in_fifo_wr_en;
  logic        in_fifo_full;
  logic        out_fifo_rd_en;
  logic [31:0] real_out;
  logic [31:0] imag_out;
  logic        out_fifo_empty;

  fm_mod_top dut (
    .clk            (clk),
    .reset          (reset),
    .din            (din),
    .in_fifo_wr_en  (in_fifo_wr_en),
    .in_fifo_full   (in_fifo_full),
    .out_fifo_rd_en (out_fifo_rd_en),
    .real_out       (real_out),
    .imag_out       (imag_out),
    .out_fifo_empty (out_fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  vec_t        tbl [14];
  logic [31:0] smp [NBP];
  logic [31:0] bp_re [NBP];
  logic [31:0] bp_im [NBP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input logic [31:0] act, input int exp);
    int d;
    d = $signed(act) - exp;
    checks++;
    if (d > 1 || d < -1) begin
      errors++;
      $display("FAIL %s: got %h expected %h +/-1", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    din = v;
    in_fifo_wr_en = 1'b1;
    @(negedge clk);
    in_fifo_wr_en = 1'b0;
  endtask

  task automatic pop();
    out_fifo_rd_en = 1'b1;
    @(negedge clk);
    out_fifo_rd_en = 1'b0;
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 40 && out_fifo_empty; i++) @(negedge clk);
    chk(name, 32'(out_fifo_empty), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic        early;
    logic        will_take, pop_now;
    logic [31:0] ph;
    logic signed [31:0] si;
    logic [11:0] t;
    real         th;
    int          n, stall, got, cyc;

    // phase after each entry noted; starts at 0
    tbl[0]  = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0400}; // 4000_0000
    tbl[1]  = '{32'h4000_0000, 32'hFFFF_FC00, 32'h0000_0000}; // 8000_0000
    tbl[2]  = '{32'h4000_0000, 32'h0000_0000, 32'hFFFF_FC00}; // C000_0000
    tbl[3]  = '{32'h4000_0000, 32'h0000_0400, 32'h0000_0000}; // 0 (wrap)
    tbl[4]  = '{32'hC000_0000, 32'h0000_0000, 32'hFFFF_FC00}; // C000_0000
    tbl[5]  = '{32'h4000_0000, 32'h0000_0400, 32'h0000_0000}; // 0
    tbl[6]  = '{32'h2000_0000, 32'h0000_02D4, 32'h0000_02D4}; // 2000_0000
    tbl[7]  = '{32'hE000_0000, 32'h0000_0400, 32'h0000_0000}; // 0
    tbl[8]  = '{32'h1000_0000, 32'h0000_03B2, 32'h0000_0188}; // 1000_0000
    tbl[9]  = '{32'h7000_0000, 32'hFFFF_FC00, 32'h0000_0000}; // 8000_0000
    tbl[10] = '{32'h9000_0000, 32'h0000_03B2, 32'h0000_0188}; // 1000_0000 (wrap)
    tbl[11] = '{32'h0000_0001, 32'h0000_03B2, 32'h0000_0188}; // 1000_0001 truncated
    tbl[12] = '{32'hD000_0000, 32'h0000_02D4, 32'hFFFF_FD2C}; // E000_0001
    tbl[13] = '{32'h1FFF_FFFF, 32'h0000_0400, 32'h0000_0000}; // 0

    ph = '0;
    for (int k = 0; k < NBP; k++) begin
      smp[k] = 32'(k) * 32'h0135_79BD + 32'h0246_8ACE;
      si = smp[k];
`ifdef FM_MOD_SAT_EN
      if (si > 32'sh2000_0000)       si = 32'sh2000_0000;
      else if (si < -32'sh2000_0000) si = -32'sh2000_0000;
`endif
      ph = ph + si;
      t  = ph[31:20];
      th = real'(t) * 2.0 * PI_TB / 4096.0;
      bp_re[k] = int'($cos(th) * 1024.0);
      bp_im[k] = int'($sin(th) * 1024.0);
    end

    reset = 1'b0;
    din = '0;
    in_fifo_wr_en = 1'b0;
    out_fifo_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_full",   32'(in_fifo_full),   32'd0);
    chk("rst_out_empty", 32'(out_fifo_empty), 32'd1);
    chk("rst_real",      real_out,            32'd0);
    chk("rst_imag",      imag_out,            32'd0);
    reset = 1'b1;
    @(negedge clk);

    // din written at edge 0; output must appear only after edge 5
    push(32'h0);
    early = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (!out_fifo_empty) early = 1'b1;
    end
    chk("lat_early", 32'(early), 32'd0);
    @(negedge clk);
    chk("lat_edge5", 32'(out_fifo_empty), 32'd0);
    chk("zero_real", real_out, 32'h0000_0400);
    chk("zero_imag", imag_out, 32'h0000_0000);
    pop();
    chk("zero_popped", 32'(out_fifo_empty), 32'd1);

`ifdef FM_MOD_SAT_EN
    push(32'h7FFF_FFFF);
    wait_out("sat_wait");
    chk_near("sat_real", real_out, 32'h2D4);
    chk_near("sat_imag", imag_out, 32'h2D4);
    pop();
`else
    for (int v = 0; v < 14; v++) begin
      push(tbl[v].din);
      wait_out($sformatf("tbl%0d_wait", v));
      chk($sformatf("tbl%0d_real", v), real_out, tbl[v].exp_re);
      chk($sformatf("tbl%0d_imag", v), imag_out, tbl[v].exp_im);
      pop();
      chk($sformatf("tbl%0d_empty", v), 32'(out_fifo_empty), 32'd1);
    end
`endif

    // Backpressure: no reads until both FIFOs fill
    pulse_reset();
    n = 0;
    stall = 0;
    while (n < NBP && stall < 60) begin
      din = smp[n];
      in_fifo_wr_en = 1'b1;
      will_take = !in_fifo_full;
      @(negedge clk);
      if (will_take) begin
        n++;
        stall = 0;
      end else begin
        stall++;
      end
    end
    in_fifo_wr_en = 1'b0;
    chk("bp_accepted", 32'(n), 32'd32);
    chk("bp_in_full", 32'(in_fifo_full), 32'd1);
    chk("bp_out_nonempty", 32'(out_fifo_empty), 32'd0);

    got = 0;
    cyc = 0;
    while (got < NBP && cyc < 2000) begin
      will_take = 1'b0;
      pop_now = 1'b0;
      if (n < NBP) begin
        din = smp[n];
        in_fifo_wr_en = 1'b1;
        will_take = !in_fifo_full;
      end else begin
        in_fifo_wr_en = 1'b0;
      end
      if (!out_fifo_empty) begin
        chk($sformatf("bp%0d_real", got), real_out, bp_re[got]);
        chk($sformatf("bp%0d_imag", got), imag_out, bp_im[got]);
        out_fifo_rd_en = 1'b1;
        pop_now = 1'b1;
      end else begin
        out_fifo_rd_en = 1'b0;
      end
      @(negedge clk);
      if (will_take) n++;
      if (pop_now) got++;
      cyc++;
    end
    in_fifo_wr_en = 1'b0;
    out_fifo_rd_en = 1'b0;
    chk("bp_drained", 32'(got), 32'(NBP));
    @(negedge clk);
    chk("bp_final_empty", 32'(out_fifo_empty), 32'd1);

    // Reset while the second sample sits in S_LUT
    pulse_reset();
    push(32'h4000_0000);
    wait_out("mr_first_wait");
    push(32'h4000_0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_empty", 32'(out_fifo_empty), 32'd1);
    chk("mr_real",  real_out,            32'd0);
    chk("mr_imag",  imag_out,            32'd0);
    chk("mr_full",  32'(in_fifo_full),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pop();
    chk("mr_rd_empty_ignored", 32'(out_fifo_empty), 32'd1);
    push(32'h0);
    wait_out("mr_after_wait");
    chk("mr_after_real", real_out, 32'h0000_0400);
    chk("mr_after_imag", imag_out, 32'h0000_0000);
    pop();
    repeat (8) @(negedge clk);
    chk("mr_no_stale", 32'(out_fifo_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
